regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised architectural register file with a built-in busy-bit scoreboard, the next generation of the multicycle core's register file. It supports configurable data width, register count (RV32I or RV32E) and read-port count. Reads are registered with write-first bypass. x0 is hardwired to zero. A per-register busy bit lets the issue stage detect read-after-write hazards against in-flight multicycle or load results. It sits between decode/issue, which reads operands and claims destinations, and writeback, which writes data and releases claims.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers (32 or 16); AW = $clog2(NREG)
- NRD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write forwarded to read data; 0 = read returns old value
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rd_en  in  NRD  per-port read strobe
- rd_addr  in  NRD×AW  per-port read address
- rd_data  out  NRD×XLEN  registered read data
- rd_busy  out  NRD  registered: addressed register is claimed (hazard)
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback address
- wr_data  in  XLEN  writeback data
- claim_en  in  1  issue claims destination register
- claim_addr  in  AW  destination being claimed
- busy_vec  out  NREG  current busy bits, bit 0 always 0
- dbg_regs  out  NREG×XLEN  flat view of all registers for the difftest/trace harness

## Operation
- Write: on a clk edge with wr_en=1 and wr_addr≠0, rf[wr_addr] ← wr_data. Writes to x0 are dropped, and rf[0] reads 0 at all times.
- Read port i: on a clk edge with rd_en[i]=1, rd_data[i] ← value of rf[rd_addr[i]]. With rd_en[i]=0, rd_data[i] and rd_busy[i] hold their values.
- Bypass (BYPASS=1): if wr_en=1, wr_addr=rd_addr[i] and the address ≠0 in the same cycle, rd_data[i] ← wr_data (write-first). With BYPASS=0 the pre-write value is returned.
- Scoreboard, per register r≠0:
  - busy[r] is set by claim_en with claim_addr=r.
  - busy[r] is cleared by wr_en with wr_addr=r.
  - If the claim and the write hit the same r in the same cycle, the claim wins and busy stays 1 (back-to-back producers).
  - Claims and writes to x0 are ignored, so busy[0] ≡ 0.
- rd_busy[i] captures the next-state busy bit of rd_addr[i]. A same-cycle writeback therefore shows not-busy, and a same-cycle claim shows busy.
- A write to an unclaimed register is legal. It updates data and leaves busy at 0.
- A second claim of an already-busy register is legal. busy stays 1 and is released by the next write.
- Multiple read ports may address the same register and receive identical results.

## Timing
- Read latency is 1 cycle: address at edge N, data valid after edge N+1.
- A write is architecturally visible to a read issued in the same cycle only when BYPASS=1. It is always visible to reads issued one cycle later.
- busy_vec and dbg_regs come directly from state flops, with no combinational path from inputs.
- Reset (rst=1 at an edge) has priority over all other inputs:
  - all rf entries → 0
  - busy → 0
  - rd_data → 0
  - rd_busy → 0
- Reset asserted mid-operation discards pending claims. A write presented in the reset cycle is lost.
- Outputs are valid from the first edge after rst deasserts.

## Structure
- Shared package rf_pkg holds:
  - default XLEN/NREG constants
  - function rf_aw(NREG)
  - typedef for the read-port request struct (en, addr)
- Sub-module rf_scoreboard(NREG) owns the busy bits and the claim/write priority. It exports the next-state vector for rd_busy lookup and the registered vector for busy_vec.
- Storage, bypass muxing and read registers stay in regfile_sb, with one generate loop over NRD.

## Test plan
- Reset: fill registers with 0xDEADBEEF, assert rst one cycle → every dbg_regs entry 0, busy_vec 0, rd_data 0 next cycle.
- x0: wr_en, addr 0, data 0x1234; claim 0 → rd_data from addr 0 stays 0, busy_vec[0]=0.
- Bypass: write x5=0xA5A5A5A5 while both ports read x5 → BYPASS=1 returns 0xA5A5A5A5 on both. BYPASS=0 returns the old value, then the new value one cycle later.
- Scoreboard: claim x7 at cycle 0 → rd_busy=1 for reads of x7 at cycles 0..2. Write x7=0x77 at cycle 3 → a read in cycle 3 returns 0x77 with rd_busy=0.
- Claim/write collision: x9 busy; same cycle write x9=0x99 and claim x9 → busy_vec[9] stays 1, rf[9]=0x99.
- Parameter sweep: NREG=16, NRD=3, XLEN=64 → random writes/claims/reads vs. a golden model over 10k cycles with zero mismatches. Addresses stay in range and ports are independent.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the scoreboarded register file.
package rf_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned NREG_DEF = 32;
    // Widest address any supported configuration needs (32 registers).
    localparam int unsigned AW_MAX   = 5;

    // Address width for a given register count.
    function automatic int unsigned rf_aw(input int unsigned nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

    // One read-port request; the address is held zero-extended to AW_MAX.
    typedef struct packed {
        logic              en;
        logic [AW_MAX-1:0] addr;
    } rd_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: claims set a bit, writebacks clear it, claim wins on collision.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    localparam int unsigned AW  = rf_aw(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic            claim_en,
    input  logic [AW-1:0]   claim_addr,
    output logic [NREG-1:0] busy_next,
    output logic [NREG-1:0] busy_q
);

    logic [NREG-1:0] busy_d;

    // Next-state busy bits; the claim is applied last so it overrides a same-cycle release.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (claim_en) begin
            busy_d[claim_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy-bit state; reset discards every outstanding claim.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_next = busy_d;

endmodule

// File: rtl/regfile_sb.sv
// Architectural register file with registered, optionally bypassed reads and a busy scoreboard.
module regfile_sb
    import rf_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREG   = NREG_DEF,
    parameter int unsigned NRD    = 2,
    parameter bit          BYPASS = 1'b1,
    localparam int unsigned AW    = rf_aw(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [XLEN-1:0]      wr_data,
    input  logic                 claim_en,
    input  logic [AW-1:0]        claim_addr,
    output logic [NREG-1:0]      busy_vec,
    output logic [NREG*XLEN-1:0] dbg_regs
);

    logic [XLEN-1:0] rf_q [NREG];
    logic [NREG-1:0] busy_next;

    rf_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .busy_next  (busy_next),
        .busy_q     (busy_vec)
    );

    // Register storage; entry 0 is only ever loaded by reset, so it stays zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                rf_q[r] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            rf_q[wr_addr] <= wr_data;
        end
    end

    for (genvar r = 0; r < NREG; r++) begin : g_dbg
        assign dbg_regs[r*XLEN +: XLEN] = rf_q[r];
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        rd_req_t         req;
        logic [XLEN-1:0] data_d;
        logic [XLEN-1:0] data_q;
        logic            busy_q;

        assign req = '{en: rd_en[i], addr: AW_MAX'(rd_addr[i*AW +: AW])};

        // Storage read with write-first forwarding of a same-cycle writeback.
        always_comb begin
            data_d = rf_q[req.addr[AW-1:0]];
            if (BYPASS && wr_en && (AW_MAX'(wr_addr) == req.addr) && (req.addr != '0)) begin
                data_d = wr_data;
            end
        end

        // Read-port output registers; they hold while the port is idle.
        always_ff @(posedge clk) begin
            if (rst) begin
                data_q <= '0;
                busy_q <= 1'b0;
            end else if (req.en) begin
                data_q <= data_d;
                busy_q <= busy_next[req.addr[AW-1:0]];
            end
        end

        assign rd_data[i*XLEN +: XLEN] = data_q;
        assign rd_busy[i]              = busy_q;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus pushes expected outputs, a monitor pops and compares.
module tb_regfile_sb;
    import rf_pkg::*;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREG   = 32;
    localparam int unsigned NRD    = 2;
    localparam bit          BYPASS = 1'b1;
    localparam int unsigned AW     = rf_aw(NREG);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NRD-1:0]       rd_en = '0;
    logic [NRD*AW-1:0]    rd_addr = '0;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic                 wr_en = 1'b0;
    logic [AW-1:0]        wr_addr = '0;
    logic [XLEN-1:0]      wr_data = '0;
    logic                 claim_en = 1'b0;
    logic [AW-1:0]        claim_addr = '0;
    logic [NREG-1:0]      busy_vec;
    logic [NREG*XLEN-1:0] dbg_regs;

    regfile_sb #(
        .XLEN   (XLEN),
        .NREG   (NREG),
        .NRD    (NRD),
        .BYPASS (BYPASS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .busy_vec   (busy_vec),
        .dbg_regs   (dbg_regs)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NRD*XLEN-1:0]  rd_data;
        logic [NRD-1:0]       rd_busy;
        logic [NREG-1:0]      busy;
        logic [NREG*XLEN-1:0] regs;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Architectural reference state.
    logic [XLEN-1:0] m_rf [NREG];
    logic            m_busy [NREG];
    logic [XLEN-1:0] m_rdd [NRD];
    logic            m_rdb [NRD];

    function automatic logic [NRD*AW-1:0] all_ports(input logic [AW-1:0] a);
        return {NRD{a}};
    endfunction

    // Drive one cycle of inputs, advance the reference model, queue the expected outputs.
    task automatic step(input logic r, input logic [NRD-1:0] re, input logic [NRD*AW-1:0] ra,
                        input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                        input logic ce, input logic [AW-1:0] ca);
        exp_t e;
        logic nb [NREG];
        int   a;
        @(negedge clk);
        rst = r; rd_en = re; rd_addr = ra;
        wr_en = we; wr_addr = wa; wr_data = wd;
        claim_en = ce; claim_addr = ca;
        if (r) begin
            for (int k = 0; k < NREG; k++) begin
                m_rf[k] = '0;
                m_busy[k] = 1'b0;
            end
            for (int p = 0; p < NRD; p++) begin
                m_rdd[p] = '0;
                m_rdb[p] = 1'b0;
            end
        end else begin
            // Busy after this edge: a writeback releases, a claim sets and wins a tie.
            for (int k = 0; k < NREG; k++) begin
                nb[k] = m_busy[k];
                if (we && int'(wa) == k) nb[k] = 1'b0;
                if (ce && int'(ca) == k) nb[k] = 1'b1;
                if (k == 0) nb[k] = 1'b0;
            end
            for (int p = 0; p < NRD; p++) begin
                if (re[p]) begin
                    a = int'(ra[p*AW +: AW]);
                    if (a == 0) m_rdd[p] = '0;
                    else if (BYPASS && we && int'(wa) == a) m_rdd[p] = wd;
                    else m_rdd[p] = m_rf[a];
                    m_rdb[p] = nb[a];
                end
            end
            if (we && wa != '0) m_rf[wa] = wd;
            for (int k = 0; k < NREG; k++) m_busy[k] = nb[k];
        end
        for (int p = 0; p < NRD; p++) begin
            e.rd_data[p*XLEN +: XLEN] = m_rdd[p];
            e.rd_busy[p] = m_rdb[p];
        end
        for (int k = 0; k < NREG; k++) begin
            e.busy[k] = m_busy[k];
            e.regs[k*XLEN +: XLEN] = m_rf[k];
        end
        q.push_back(e);
    endtask

    // Monitor: after each edge, pop the expected outputs for that edge and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (rd_data !== e.rd_data) begin
                    n_err++;
                    $display("FAIL rd_data t=%0t got %h want %h", $time, rd_data, e.rd_data);
                end
                n_cmp++;
                if (rd_busy !== e.rd_busy) begin
                    n_err++;
                    $display("FAIL rd_busy t=%0t got %b want %b", $time, rd_busy, e.rd_busy);
                end
                n_cmp++;
                if (busy_vec !== e.busy) begin
                    n_err++;
                    $display("FAIL busy_vec t=%0t got %h want %h", $time, busy_vec, e.busy);
                end
                n_cmp++;
                if (dbg_regs !== e.regs) begin
                    n_err++;
                    $display("FAIL dbg_regs t=%0t got %h want %h", $time, dbg_regs, e.regs);
                end
            end
        end
    end

    initial begin
        logic [NRD*AW-1:0] ra;
        int                guard;

        // Reset from power-up.
        step(1'b1, '0, '0, 1'b0, '0, '0, 1'b0, '0);
        step(1'b1, '0, '0, 1'b0, '0, '0, 1'b0, '0);

        // Fill every register and claim some, then reset mid-operation.
        for (int r = 1; r < NREG; r++) begin
            step(1'b0, '1, all_ports(AW'(r)), 1'b1, AW'(r), XLEN'(32'hDEADBEEF), 1'b1, AW'(r));
        end
        step(1'b1, '1, all_ports(AW'(3)), 1'b1, AW'(4), XLEN'(32'h55), 1'b1, AW'(6));
        step(1'b0, '1, all_ports(AW'(3)), 1'b0, '0, '0, 1'b0, '0);

        // x0: writes and claims are dropped.
        step(1'b0, '1, all_ports('0), 1'b1, '0, XLEN'(32'h1234), 1'b1, '0);
        step(1'b0, '1, all_ports('0), 1'b0, '0, '0, 1'b0, '0);

        // Bypass: same-cycle write to x5 seen by all ports, then the stored value.
        step(1'b0, '0, '0, 1'b1, AW'(5), XLEN'(32'h11111111), 1'b0, '0);
        step(1'b0, '1, all_ports(AW'(5)), 1'b1, AW'(5), XLEN'(32'hA5A5A5A5), 1'b0, '0);
        step(1'b0, '1, all_ports(AW'(5)), 1'b0, '0, '0, 1'b0, '0);

        // Scoreboard: claim x7, stay busy, release on writeback with a same-cycle read.
        step(1'b0, '1, all_ports(AW'(7)), 1'b0, '0, '0, 1'b1, AW'(7));
        step(1'b0, '1, all_ports(AW'(7)), 1'b0, '0, '0, 1'b0, '0);
        step(1'b0, '1, all_ports(AW'(7)), 1'b0, '0, '0, 1'b0, '0);
        step(1'b0, '1, all_ports(AW'(7)), 1'b1, AW'(7), XLEN'(32'h77), 1'b0, '0);
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);

        // Collision on x9: claim wins, data still written.
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, AW'(9));
        step(1'b0, '1, all_ports(AW'(9)), 1'b1, AW'(9), XLEN'(32'h99), 1'b1, AW'(9));
        step(1'b0, '1, all_ports(AW'(9)), 1'b0, '0, '0, 1'b0, '0);
        // Double claim then a single write releases it.
        step(1'b0, '1, all_ports(AW'(9)), 1'b0, '0, '0, 1'b1, AW'(9));
        step(1'b0, '1, all_ports(AW'(9)), 1'b1, AW'(9), XLEN'(32'h9A), 1'b0, '0);

        // Random traffic with independent ports and occasional reset.
        for (int n = 0; n < 3000; n++) begin
            for (int p = 0; p < NRD; p++) ra[p*AW +: AW] = AW'($urandom_range(NREG - 1));
            step(($urandom_range(63) == 0), NRD'($urandom), ra,
                 ($urandom_range(1) == 1), AW'($urandom_range(NREG - 1)),
                 XLEN'({$urandom(), $urandom()}),
                 ($urandom_range(9) < 3), AW'($urandom_range(NREG - 1)));
        end
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (q.size() > 0) begin
            n_err++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
